uart_cmd_decoder: RTL

Turns the UART receiver's byte stream into one-cycle command pulses for `control_unit`: virtual buttons, switch-toggle requests, toggle clear, and report requests. It sits between `uart_rx` and `control_unit`. Each command is one ASCII character followed by CR or LF, parsed by a small framing FSM with error and timeout handling. Virtual button outputs can be stretched so they are seen like physical button presses.

---
 rtl/uart_cmd_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// Frames single-character UART commands terminated by CR/LF into command pulses
// and stretched virtual button presses for control_unit.
module uart_cmd_decoder #(
    parameter int BTN_HOLD_CYCLES = 1,
    parameter int TIMEOUT_CYCLES  = 100_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    output logic       oBtnC,
    output logic       oBtnU,
    output logic       oBtnD,
    output logic       oBtnL,
    output logic       oBtnR,
    output logic       oTglSw0,
    output logic       oTglSw1,
    output logic       oTglSw2,
    output logic       oTglSw3,
    output logic       oClrSwTgl,
    output logic       oReqWatchRpt,
    output logic       oReqSr04Rpt,
    output logic       oReqTempRpt,
    output logic       oReqHumRpt,
    output logic       oCmdErr
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int HW = (BTN_HOLD_CYCLES > 1) ? $clog2(BTN_HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TMO       = TW'(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BTN_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GOT_CMD, DISCARD} state_t;

    state_t          state, stateNext;
    logic [3:0]      cmdCode, cmdNext;
    logic [TW-1:0]   idleCnt, idleCntNext;
    logic [2:0]      activeBtn, btnNext;
    logic [HW-1:0]   holdCnt, holdNext;
    logic            errNext, execVld, isTerm;
    logic [4:0]      rxDec;

    // Returns {valid, code}; codes 0-4 are the buttons C/U/D/L/R.
    function automatic logic [4:0] decodeByte(input logic [7:0] b);
        logic [7:0] u;
        u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        case (u)
            "C": return {1'b1, 4'd0};
            "U": return {1'b1, 4'd1};
            "D": return {1'b1, 4'd2};
            "L": return {1'b1, 4'd3};
            "R": return {1'b1, 4'd4};
            "0": return {1'b1, 4'd5};
            "1": return {1'b1, 4'd6};
            "2": return {1'b1, 4'd7};
            "3": return {1'b1, 4'd8};
            "X": return {1'b1, 4'd9};
            "W": return {1'b1, 4'd10};
            "S": return {1'b1, 4'd11};
            "T": return {1'b1, 4'd12};
            "H": return {1'b1, 4'd13};
            default: return 5'd0;
        endcase
    endfunction

    always_comb begin
        rxDec       = decodeByte(iRxData);
        isTerm      = (iRxData == 8'h0D) || (iRxData == 8'h0A);
        stateNext   = state;
        cmdNext     = cmdCode;
        idleCntNext = '0;
        errNext     = 1'b0;
        execVld     = 1'b0;
        if (iRxValid) begin
            case (state)
                IDLE: begin
                    if (!isTerm) begin
                        if (rxDec[4]) begin
                            cmdNext   = rxDec[3:0];
                            stateNext = GOT_CMD;
                        end else begin
                            errNext   = 1'b1;
                            stateNext = DISCARD;
                        end
                    end
                end
                GOT_CMD: begin
                    stateNext = isTerm ? IDLE : DISCARD;
                    execVld   = isTerm;
                    errNext   = !isTerm;
                end
                DISCARD: if (isTerm) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end else if (state != IDLE && TIMEOUT_CYCLES > 0) begin
            idleCntNext = idleCnt + 1'b1;
            if (idleCntNext == TMO) begin
                idleCntNext = '0;
                stateNext   = IDLE;
                errNext     = (state == GOT_CMD);
            end
        end
    end

    // A new button execute overrides any hold in progress.
    always_comb begin
        btnNext  = activeBtn;
        holdNext = holdCnt;
        if (activeBtn != 3'd0) begin
            if (holdCnt == '0) btnNext = 3'd0;
            else               holdNext = holdCnt - 1'b1;
        end
        if (execVld && cmdCode <= 4'd4) begin
            btnNext  = 3'(cmdCode + 4'd1);
            holdNext = HOLD_LAST;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state        <= IDLE;
            idleCnt      <= '0;
            activeBtn    <= 3'd0;
            holdCnt      <= '0;
            oBtnC        <= 1'b0;
            oBtnU        <= 1'b0;
            oBtnD        <= 1'b0;
            oBtnL        <= 1'b0;
            oBtnR        <= 1'b0;
            oTglSw0      <= 1'b0;
            oTglSw1      <= 1'b0;
            oTglSw2      <= 1'b0;
            oTglSw3      <= 1'b0;
            oClrSwTgl    <= 1'b0;
            oReqWatchRpt <= 1'b0;
            oReqSr04Rpt  <= 1'b0;
            oReqTempRpt  <= 1'b0;
            oReqHumRpt   <= 1'b0;
            oCmdErr      <= 1'b0;
        end else begin
            state        <= stateNext;
            idleCnt      <= idleCntNext;
            activeBtn    <= btnNext;
            holdCnt      <= holdNext;
            oBtnC        <= (btnNext == 3'd1);
            oBtnU        <= (btnNext == 3'd2);
            oBtnD        <= (btnNext == 3'd3);
            oBtnL        <= (btnNext == 3'd4);
            oBtnR        <= (btnNext == 3'd5);
            oTglSw0      <= execVld && (cmdCode == 4'd5);
            oTglSw1      <= execVld && (cmdCode == 4'd6);
            oTglSw2      <= execVld && (cmdCode == 4'd7);
            oTglSw3      <= execVld && (cmdCode == 4'd8);
            oClrSwTgl    <= execVld && (cmdCode == 4'd9);
            oReqWatchRpt <= execVld && (cmdCode == 4'd10);
            oReqSr04Rpt  <= execVld && (cmdCode == 4'd11);
            oReqTempRpt  <= execVld && (cmdCode == 4'd12);
            oReqHumRpt   <= execVld && (cmdCode == 4'd13);
            oCmdErr      <= errNext;
        end
    end

    // The latched command is only consumed after it has been written in GOT_CMD.
    always_ff @(posedge iClk) begin
        cmdCode <= cmdNext;
    end

endmodule
